alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters, for example the execute stage and the address/branch-target unit of the multicycle variant.
- Selects one requester per cycle by round-robin and drives the ALU with its operands.
- Registers the ALU result and returns it on one shared response channel, tagged with the requester ID, under valid/ready handshake.
- Throughput is one operation per cycle when the response side is not stalled.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 32 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation encoding and legality check.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_PASS_B = 4'b1001,
    ALU_SRA    = 4'b1101
  } alu_op_e;

  function automatic logic is_legal_alu_op(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_OR, ALU_AND, ALU_SUB, ALU_PASS_B, ALU_SRA: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown op codes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_res
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:    alu_res = a + b;
      ALU_SUB:    alu_res = a - b;
      ALU_SLL:    alu_res = a << shamt;
      ALU_SRL:    alu_res = a >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(a) >>> shamt);
      ALU_XOR:    alu_res = a ^ b;
      ALU_OR:     alu_res = a | b;
      ALU_AND:    alu_res = a & b;
      ALU_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_PASS_B: alu_res = b;
      default:    alu_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, with a registered
// result returned on a single tagged valid/ready response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_result,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_err
);

  typedef enum logic {S_IDLE, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0] resp_result_q, resp_result_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic            resp_err_q, resp_err_d;

  logic [XLEN-1:0] a_arr  [NUM_REQ];
  logic [XLEN-1:0] b_arr  [NUM_REQ];
  logic [3:0]      op_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*XLEN +: XLEN];
      assign b_arr[gi]  = req_b[gi*XLEN +: XLEN];
      assign op_arr[gi] = req_op[gi*4 +: 4];
    end
  endgenerate

  // Returns {found, index} of the first valid requester at or after ptr, wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] pos;
    int              idx;
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = idx[ID_W-1:0];
      if (valid[pos]) pick = {1'b1, pos};
    end
    return pick;
  endfunction

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            can_accept;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [3:0]      op_sel;

  assign {grant_found, grant_idx} = rr_pick(req_valid, rr_ptr_q);
  assign can_accept = rst_n && ((state_q == S_IDLE) || resp_ready);
  assign accept     = can_accept && grant_found;
  assign op_sel     = op_arr[grant_idx];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  alu u_alu (
    .a      (a_arr[grant_idx]),
    .b      (b_arr[grant_idx]),
    .alu_op (op_sel),
    .alu_res(alu_res)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    resp_result_d = resp_result_q;
    resp_id_d     = resp_id_q;
    resp_err_d    = resp_err_q;
    if (accept) begin
      state_d       = S_RESP;
      resp_result_d = alu_res;
      resp_id_d     = grant_idx;
      resp_err_d    = !is_legal_alu_op(op_sel);
      // Explicit wrap keeps non-power-of-two requester counts in range.
      rr_ptr_d      = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if ((state_q == S_RESP) && resp_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      resp_result_q <= resp_result_d;
      resp_id_q     <= resp_id_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign resp_valid  = (state_q == S_RESP);
  assign resp_result = resp_result_q;
  assign resp_id     = resp_id_q;
  assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a 2-requester and a 3-requester instance, table vectors,
// directed multi-cycle sequences and a randomized run against a reference model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  rv2, rdy2;
  logic [63:0] ra2, rb2;
  logic [7:0]  rop2;
  logic        rvld2, rr2, err2;
  logic [31:0] res2;
  logic [0:0]  id2;

  logic [2:0]  rv3, rdy3;
  logic [95:0] ra3, rb3;
  logic [11:0] rop3;
  logic        rvld3, rr3, err3;
  logic [31:0] res3;
  logic [1:0]  id3;

  alu_arbiter #(.NUM_REQ(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv2), .req_ready(rdy2),
    .req_a(ra2), .req_b(rb2), .req_op(rop2),
    .resp_valid(rvld2), .resp_ready(rr2), .resp_result(res2),
    .resp_id(id2), .resp_err(err2)
  );

  alu_arbiter #(.NUM_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_ready(rdy3),
    .req_a(ra3), .req_b(rb3), .req_op(rop3),
    .resp_valid(rvld3), .resp_ready(rr3), .resp_result(res3),
    .resp_id(id3), .resp_err(err3)
  );

  // A requester never withdraws before it has been accepted.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_contract
      assert property (@(posedge clk) disable iff (!rst_n)
                       (rv2[gi] && !rdy2[gi]) |=> rv2[gi])
        else $error("requester %0d dropped valid before accept", gi);
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst_n = 1'b0; rv2 = '0; rv3 = '0; rr2 = 1'b1; rr3 = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req2(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    rv2[i] = 1'b1; rop2[i*4 +: 4] = op; ra2[i*32 +: 32] = a; rb2[i*32 +: 32] = b;
  endtask

  task automatic set_req3(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    rv3[i] = 1'b1; rop3[i*4 +: 4] = op; ra3[i*32 +: 32] = a; rb3[i*32 +: 32] = b;
  endtask

  task automatic chk_resp2(input string name, input logic [31:0] res, input int id, input logic err);
    chk({name, "_valid"}, 32'(rvld2), 32'd1);
    chk({name, "_result"}, res2, res);
    chk({name, "_id"}, 32'(id2), 32'(id));
    chk({name, "_err"}, 32'(err2), 32'(err));
  endtask

  // Reference ALU computed directly from the operation definitions.
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b % 32;
    case (op)
      4'd0:  return {1'b0, a + b};
      4'd8:  return {1'b0, a - b};
      4'd1:  return {1'b0, a << s};
      4'd5:  return {1'b0, a >> s};
      4'd13: return {1'b0, (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0)};
      4'd4:  return {1'b0, a ^ b};
      4'd6:  return {1'b0, a | b};
      4'd7:  return {1'b0, a & b};
      4'd2:  return {1'b0, 31'd0, ($signed(a) < $signed(b))};
      4'd3:  return {1'b0, 31'd0, (a < b)};
      4'd9:  return {1'b0, b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] legal [11] = '{4'd0, 4'd8, 4'd1, 4'd5, 4'd13, 4'd4, 4'd6, 4'd7, 4'd2, 4'd3, 4'd9};
    if ($urandom_range(0, 9) == 0) return 4'($urandom);
    return legal[$urandom_range(0, 10)];
  endfunction

  typedef struct {
    int          req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs [14];

  task automatic apply_vec(input int k, input vec_t v);
    rr2 = 1'b1;
    set_req2(v.req, v.op, v.a, v.b);
    samp();
    chk($sformatf("vec%0d_ready", k), 32'(rdy2), 32'(1 << v.req));
    tick();
    rv2[v.req] = 1'b0;
    samp();
    chk_resp2($sformatf("vec%0d", k), v.res, v.req, v.err);
    tick();
    samp();
    chk($sformatf("vec%0d_idle", k), 32'(rvld2), 32'd0);
    tick();
  endtask

  int          m_ptr, g, acc;
  logic        m_pending, m_err, can;
  logic [31:0] m_res;
  int          m_id;
  logic [32:0] r;

  initial begin
    vecs[0]  = '{0, 4'b1000, 32'd7,          32'd5,        32'd2,          1'b0};
    vecs[1]  = '{0, 4'b0000, 32'd1,          32'd1,        32'd2,          1'b0};
    vecs[2]  = '{1, 4'b0001, 32'd1,          32'd35,       32'd8,          1'b0};
    vecs[3]  = '{1, 4'b0101, 32'h8000_0000,  32'd4,        32'h0800_0000,  1'b0};
    vecs[4]  = '{0, 4'b1101, 32'h8000_0000,  32'd4,        32'hF800_0000,  1'b0};
    vecs[5]  = '{1, 4'b0100, 32'hF0,         32'h0F,       32'hFF,         1'b0};
    vecs[6]  = '{0, 4'b0110, 32'hF0,         32'h3C,       32'hFC,         1'b0};
    vecs[7]  = '{1, 4'b0111, 32'hF0,         32'h3C,       32'h30,         1'b0};
    vecs[8]  = '{0, 4'b0010, 32'hFFFF_FFFF,  32'd1,        32'd1,          1'b0};
    vecs[9]  = '{1, 4'b0011, 32'hFFFF_FFFF,  32'd1,        32'd0,          1'b0};
    vecs[10] = '{0, 4'b1001, 32'd5,          32'h1234,     32'h1234,       1'b0};
    vecs[11] = '{1, 4'b1111, 32'd3,          32'd4,        32'd0,          1'b1};
    vecs[12] = '{0, 4'b1010, 32'd3,          32'd4,        32'd0,          1'b1};
    vecs[13] = '{1, 4'b1000, 32'd0,          32'd1,        32'hFFFF_FFFF,  1'b0};

    rst_n = 1'b0; rv2 = 2'b11; rv3 = 3'b111; rr2 = 1'b1; rr3 = 1'b1;
    ra2 = '0; rb2 = '0; rop2 = '0; ra3 = '0; rb3 = '0; rop3 = '0;
    samp();
    chk("rst_ready", 32'(rdy2), 32'd0);
    chk("rst_ready3", 32'(rdy3), 32'd0);
    chk("rst_valid", 32'(rvld2), 32'd0);
    chk("rst_result", res2, 32'd0);
    chk("rst_id", 32'(id2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    reset_all();

    for (int k = 0; k < 14; k++) apply_vec(k, vecs[k]);

    // Contention: strict alternation, one result per cycle.
    reset_all();
    set_req2(0, 4'b0000, 32'd1, 32'd1);
    set_req2(1, 4'b0100, 32'hF0, 32'h0F);
    for (int c = 0; c < 4; c++) begin
      samp();
      chk($sformatf("cont%0d_ready", c), 32'(rdy2), (c % 2 == 0) ? 32'd1 : 32'd2);
      if (c > 0) chk_resp2($sformatf("cont%0d", c), (c % 2 == 1) ? 32'd2 : 32'hFF, (c + 1) % 2, 1'b0);
      tick();
    end
    rv2[1] = 1'b0;
    samp();
    chk("cont4_ready", 32'(rdy2), 32'd1);
    chk_resp2("cont4", 32'hFF, 1, 1'b0);
    tick();
    rv2[0] = 1'b0;
    samp();
    chk_resp2("cont5", 32'd2, 0, 1'b0);
    tick();

    // Backpressure holds the result and blocks new accepts.
    reset_all();
    set_req2(0, 4'b1101, 32'h8000_0000, 32'd4);
    samp();
    chk("bp_ready0", 32'(rdy2), 32'd1);
    tick();
    rv2[0] = 1'b0; rr2 = 1'b0;
    set_req2(1, 4'b0110, 32'd5, 32'd2);
    for (int c = 0; c < 3; c++) begin
      samp();
      chk_resp2($sformatf("bp_hold%0d", c), 32'hF800_0000, 0, 1'b0);
      chk($sformatf("bp_hold%0d_ready", c), 32'(rdy2), 32'd0);
      tick();
    end
    rr2 = 1'b1;
    samp();
    chk("bp_release_ready", 32'(rdy2), 32'd2);
    chk_resp2("bp_release", 32'hF800_0000, 0, 1'b0);
    tick();
    rv2[1] = 1'b0;
    samp();
    chk_resp2("bp_next", 32'd7, 1, 1'b0);
    tick();

    // Illegal op still advances the round-robin pointer.
    reset_all();
    set_req2(0, 4'b1111, 32'd3, 32'd4);
    set_req2(1, 4'b0000, 32'd1, 32'd1);
    samp();
    chk("ill_ready0", 32'(rdy2), 32'd1);
    tick();
    rv2[0] = 1'b0;
    samp();
    chk("ill_ready1", 32'(rdy2), 32'd2);
    chk_resp2("ill", 32'd0, 0, 1'b1);
    tick();
    rv2[1] = 1'b0;
    samp();
    chk_resp2("ill_next", 32'd2, 1, 1'b0);
    tick();

    // Reset while a stalled result is pending discards it.
    reset_all();
    rr2 = 1'b0;
    set_req2(0, 4'b0000, 32'd2, 32'd3);
    samp();
    chk("mrst_ready", 32'(rdy2), 32'd1);
    tick();
    rv2[0] = 1'b0;
    samp();
    chk_resp2("mrst_pending", 32'd5, 0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    samp();
    chk("mrst_valid", 32'(rvld2), 32'd0);
    chk("mrst_result", res2, 32'd0);
    chk("mrst_id", 32'(id2), 32'd0);
    chk("mrst_err", 32'(err2), 32'd0);
    tick();
    samp();
    chk("mrst_valid2", 32'(rvld2), 32'd0);
    tick();
    rr2 = 1'b1;
    set_req2(0, 4'b0000, 32'd1, 32'd1);
    set_req2(1, 4'b0000, 32'd1, 32'd1);
    samp();
    chk("mrst_ptr", 32'(rdy2), 32'd1);
    tick();
    rv2[0] = 1'b0;
    samp();
    tick();
    rv2[1] = 1'b0;

    // Three requesters: pointer wraps from 2 back to 0.
    reset_all();
    set_req3(2, 4'b0011, 32'hFFFF_FFFF, 32'd1);
    samp();
    chk("n3_ready_r2", 32'(rdy3), 32'd4);
    tick();
    rv3[2] = 1'b0;
    set_req3(0, 4'b0010, 32'hFFFF_FFFF, 32'd1);
    set_req3(1, 4'b0000, 32'd2, 32'd3);
    samp();
    chk("n3_ready_r0", 32'(rdy3), 32'd1);
    chk("n3_id_a", 32'(id3), 32'd2);
    chk("n3_res_a", res3, 32'd0);
    tick();
    rv3[0] = 1'b0;
    samp();
    chk("n3_ready_r1", 32'(rdy3), 32'd2);
    chk("n3_id_b", 32'(id3), 32'd0);
    chk("n3_res_b", res3, 32'd1);
    tick();
    rv3[1] = 1'b0;
    samp();
    chk("n3_id_c", 32'(id3), 32'd1);
    chk("n3_res_c", res3, 32'd5);
    chk("n3_valid_c", 32'(rvld3), 32'd1);
    tick();

    // Randomized traffic against the reference model.
    reset_all();
    m_pending = 1'b0; m_ptr = 0; m_res = '0; m_id = 0; m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        if (!rv2[i] && $urandom_range(0, 99) < 60) set_req2(i, rand_op(), $urandom(), $urandom());
      rr2 = ($urandom_range(0, 99) < 70);
      samp();
      chk("rnd_valid", 32'(rvld2), 32'(m_pending));
      if (m_pending) begin
        chk("rnd_result", res2, m_res);
        chk("rnd_id", 32'(id2), 32'(m_id));
        chk("rnd_err", 32'(err2), 32'(m_err));
      end
      can = !m_pending || rr2;
      g = -1;
      for (int k = 0; k < 2; k++)
        if (g < 0 && rv2[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
      acc = (can && g >= 0) ? g : -1;
      chk("rnd_ready", 32'(rdy2), (acc >= 0) ? 32'(1 << acc) : 32'd0);
      if (acc >= 0) begin
        r = ref_alu(rop2[acc*4 +: 4], ra2[acc*32 +: 32], rb2[acc*32 +: 32]);
        m_pending = 1'b1; m_res = r[31:0]; m_err = r[32]; m_id = acc;
        m_ptr = (acc + 1) % 2;
      end else if (m_pending && rr2) begin
        m_pending = 1'b0;
      end
      tick();
      if (acc >= 0) rv2[acc] = 1'b0;
    end
    rst_n = 1'b0; rv2 = '0;
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
